// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite evaluator.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int OAM_ADDR_W   = 6;
    // Row offset inside a sprite; 4 bits covers both 8- and 16-line sprites.
    localparam int SPRITE_ROW_W = 4;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
    } oam_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } eval_state_t;

    // A sprite covers lines y .. y+h-1 with no wrap past line 255.
    function automatic logic sprite_hit(input logic [7:0] line,
                                        input logic [7:0] y,
                                        input int unsigned h);
        logic [7:0] diff;
        diff = line - y;
        return (line >= y) &&
               (diff[7:SPRITE_ROW_W] == '0) &&
               ({1'b0, diff[SPRITE_ROW_W-1:0]} < (SPRITE_ROW_W+1)'(h));
    endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// Double-banked secondary OAM: 2 x MAX_SPRITES x 32-bit entries, one write port, async read.
// Latency: write lands on the next clk_i edge; read is combinational.
// Backpressure: none; the writer owns the back bank, the reader owns the front bank.
module sprite_line_buffer #(
    parameter int MAX_SPRITES = 8
) (
    input  logic                           clk_i,
    input  logic                           wr_en_i,
    input  logic                           wr_bank_i,
    input  logic [$clog2(MAX_SPRITES)-1:0] wr_idx_i,
    input  logic [31:0]                    wr_data_i,
    input  logic                           rd_bank_i,
    input  logic [$clog2(MAX_SPRITES)-1:0] rd_idx_i,
    output logic [31:0]                    rd_data_o
);

    // Entry contents are don't-care after reset; slot validity is tracked by the counts.
    logic [31:0] mem_q [2][MAX_SPRITES];

    // Store one selected sprite into the back bank.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_idx_i];

endmodule

// File: rtl/sprite_evaluator.sv
// Scans all OAM entries per line and keeps the first MAX_SPRITES hits in a double-buffered secondary OAM.
// Latency: addr k in cycle T+1+k, data k evaluated T+2+k, eval_done at T+66 (earlier on overflow).
// Backpressure: none; a new line_start always swaps banks and restarts. Option macro: SPRITE_ZERO_FLAG_EN.
module sprite_evaluator
    import sprite_pkg::*;
#(
    parameter int MAX_SPRITES = 8,
    parameter int SPRITE_H    = 8,
    parameter int OAM_ENTRIES = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           line_start,
    input  logic [7:0]                     line_num,
    output logic [OAM_ADDR_W-1:0]          oam_read_addr,
    input  logic [31:0]                    oam_read_data,
    input  logic [$clog2(MAX_SPRITES)-1:0] sec_rd_idx,
    output logic [31:0]                    sec_rd_data,
    output logic [$clog2(MAX_SPRITES):0]   sprite_count,
    output logic                           sprite_overflow,
    output logic                           eval_done,
    output logic                           eval_late,
    output logic                           busy
`ifdef SPRITE_ZERO_FLAG_EN
    ,
    output logic                           sprite0_in_line
`endif
);

    localparam int IDX_W = $clog2(MAX_SPRITES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_ENTRIES - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(MAX_SPRITES);

    eval_state_t           state_q;
    logic [OAM_ADDR_W-1:0] addr_q;
    logic                  addr_last_q;   // every address has been issued
    logic                  vld_q;         // oam_read_data holds entry idx_q this cycle
    logic [OAM_ADDR_W-1:0] idx_q;
    logic [7:0]            line_q;
    logic                  bank_q;        // back bank being written; front is ~bank_q
    logic [CNT_W-1:0]      cnt_q;
    logic                  ovf_q;
    logic [CNT_W-1:0]      front_cnt_q;
    logic                  front_ovf_q;
    logic                  eval_done_q;
    logic                  eval_late_q;
    logic                  busy_q;

    oam_entry_t  rd_entry;
    logic        hit;
    logic        room;
    logic        buf_we;
    logic [31:0] front_data;

    assign rd_entry = oam_entry_t'(oam_read_data);
    assign hit      = sprite_hit(line_q, rd_entry.y, SPRITE_H);
    assign room     = (cnt_q < FULL_CNT);
    // A line_start in the same cycle discards the entry currently on the bus.
    assign buf_we   = (state_q == SCAN) && vld_q && hit && room && !line_start;

    sprite_line_buffer #(
        .MAX_SPRITES(MAX_SPRITES)
    ) u_buf (
        .clk_i    (clk),
        .wr_en_i  (buf_we),
        .wr_bank_i(bank_q),
        .wr_idx_i (cnt_q[IDX_W-1:0]),
        .wr_data_i(rd_entry),
        .rd_bank_i(~bank_q),
        .rd_idx_i (sec_rd_idx),
        .rd_data_o(front_data)
    );

    // Scan FSM: bank swap on line_start, address issue, hit counting and completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            addr_last_q <= 1'b0;
            vld_q       <= 1'b0;
            idx_q       <= '0;
            line_q      <= '0;
            bank_q      <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            front_cnt_q <= '0;
            front_ovf_q <= 1'b0;
            eval_done_q <= 1'b0;
            eval_late_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            eval_done_q <= 1'b0;
            eval_late_q <= 1'b0;
            if (line_start) begin
                bank_q      <= ~bank_q;
                front_cnt_q <= cnt_q;
                front_ovf_q <= ovf_q;
                cnt_q       <= '0;
                ovf_q       <= 1'b0;
                line_q      <= line_num;
                addr_q      <= '0;
                addr_last_q <= 1'b0;
                vld_q       <= 1'b0;
                state_q     <= SCAN;
                busy_q      <= 1'b1;
                eval_late_q <= (state_q == SCAN);
            end else begin
                unique case (state_q)
                    IDLE: ;
                    SCAN: begin
                        vld_q <= !addr_last_q;
                        idx_q <= addr_q;
                        if (addr_q == LAST_ADDR) begin
                            addr_last_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + OAM_ADDR_W'(1);
                        end
                        if (buf_we) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (vld_q && hit && !room) begin
                            ovf_q <= 1'b1;
                        end
                        if (vld_q && ((hit && !room) || (idx_q == LAST_ADDR))) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            eval_done_q <= 1'b1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef SPRITE_ZERO_FLAG_EN
    logic s0_q;
    logic front_s0_q;

    // Entry 0 is always the first candidate, so a write of it always lands in slot 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q       <= 1'b0;
            front_s0_q <= 1'b0;
        end else if (line_start) begin
            front_s0_q <= s0_q;
            s0_q       <= 1'b0;
        end else if (buf_we && (idx_q == '0)) begin
            s0_q <= 1'b1;
        end
    end

    assign sprite0_in_line = front_s0_q;
`endif

    assign oam_read_addr   = addr_q;
    assign sprite_count    = front_cnt_q;
    assign sprite_overflow = front_ovf_q;
    assign eval_done       = eval_done_q;
    assign eval_late       = eval_late_q;
    assign busy            = busy_q;
    // Unused slots read as Y=FF so the renderer sees them as off-screen.
    assign sec_rd_data     = ({1'b0, sec_rd_idx} >= front_cnt_q) ? 32'hFFFF_FFFF : front_data;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed plus randomized bench for sprite_evaluator against a list-based reference model.
// Latency: checks exact cycle of eval_done, eval_late and the bank swap.
// Backpressure: n/a; OAM RAM is modelled as a 1-cycle registered read.
module tb_sprite_evaluator;

    localparam int MAXS = 8;
    localparam int SH   = 8;
    localparam int NENT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        line_start;
    logic [7:0]  line_num;
    logic [5:0]  oam_read_addr;
    logic [31:0] oam_read_data;
    logic [2:0]  sec_rd_idx;
    logic [31:0] sec_rd_data;
    logic [3:0]  sprite_count;
    logic        sprite_overflow;
    logic        eval_done;
    logic        eval_late;
    logic        busy;
`ifdef SPRITE_ZERO_FLAG_EN
    logic        sprite0_in_line;
`endif

    always #20 clk = ~clk;

    sprite_evaluator #(
        .MAX_SPRITES(MAXS),
        .SPRITE_H   (SH),
        .OAM_ENTRIES(NENT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .line_start     (line_start),
        .line_num       (line_num),
        .oam_read_addr  (oam_read_addr),
        .oam_read_data  (oam_read_data),
        .sec_rd_idx     (sec_rd_idx),
        .sec_rd_data    (sec_rd_data),
        .sprite_count   (sprite_count),
        .sprite_overflow(sprite_overflow),
        .eval_done      (eval_done),
        .eval_late      (eval_late),
        .busy           (busy)
`ifdef SPRITE_ZERO_FLAG_EN
        ,
        .sprite0_in_line(sprite0_in_line)
`endif
    );

    // OAM RAM: data for the address presented in one cycle appears in the next.
    logic [31:0] oam [NENT];
    always @(posedge clk) oam_read_data <= oam[oam_read_addr];

    int          vectors    = 0;
    int          miscompares = 0;
    int          pend_cnt;
    bit          pend_ovf;
    int          pend_ovidx;
    bit          pend_s0;
    logic [31:0] pend_slot [MAXS];
    bit          have_pend  = 1'b0;

    function automatic bit is_hit(input int ln, input logic [31:0] e);
        int y;
        y = int'(e[31:24]);
        return (ln >= y) && (ln - y < SH);
    endfunction

    // Expected secondary OAM after scanning the first n entries for line ln.
    task automatic model(input int ln, input int n);
        pend_cnt   = 0;
        pend_ovf   = 1'b0;
        pend_ovidx = -1;
        pend_s0    = (n > 0) && is_hit(ln, oam[0]);
        for (int e = 0; e < n; e++) begin
            if (is_hit(ln, oam[e])) begin
                if (pend_cnt < MAXS) begin
                    pend_slot[pend_cnt] = oam[e];
                    pend_cnt++;
                end else begin
                    pend_ovf   = 1'b1;
                    pend_ovidx = e;
                    break;
                end
            end
        end
        have_pend = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed cycle %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_front(input string tag);
        chk({tag, "_cnt"}, 32'(sprite_count), 32'(pend_cnt));
        chk({tag, "_ovf"}, 32'(sprite_overflow), 32'(pend_ovf));
`ifdef SPRITE_ZERO_FLAG_EN
        chk({tag, "_s0"}, 32'(sprite0_in_line), 32'(pend_s0));
`endif
        for (int i = 0; i < MAXS; i++) begin
            sec_rd_idx = 3'(i);
            #1;
            chk($sformatf("%s_slot%0d", tag, i), sec_rd_data,
                (i < pend_cnt) ? pend_slot[i] : 32'hFFFF_FFFF);
        end
    endtask

    // Pulse line_start; returns in cycle T+1 after checking the swapped front bank.
    task automatic begin_line(input logic [7:0] ln, input bit exp_late, input string tag);
        line_num   = ln;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        chk({tag, "_late"}, 32'(eval_late), 32'(exp_late));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_addr0"}, 32'(oam_read_addr), 32'd0);
        if (have_pend) check_front(tag);
    endtask

    // Waits (bounded) for eval_done and checks its cycle relative to T.
    task automatic expect_done(input string tag);
        int cyc;
        int lo;
        int hi;
        cyc = 1;
        while (eval_done !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        lo = pend_ovf ? pend_ovidx + 3 : 66;
        hi = pend_ovf ? pend_ovidx + 4 : 66;
        chk_win({tag, "_done_cycle"}, cyc, lo, hi);
    endtask

    task automatic fill_far();
        for (int e = 0; e < NENT; e++) oam[e] = {8'd240 + 8'($urandom_range(0, 7)), 24'($urandom)};
    endtask

    task automatic fill_rand(input int ln, input int p);
        logic [7:0] y;
        for (int e = 0; e < NENT; e++) begin
            if ($urandom_range(0, p - 1) == 0) y = 8'(ln - int'($urandom_range(0, 9)));
            else                               y = 8'($urandom_range(0, 255));
            oam[e] = {y, 24'($urandom)};
        end
    endtask

    initial begin
        int ln;
        bit seen;
        reset_n    = 1'b0;
        line_start = 1'b0;
        line_num   = 8'd0;
        sec_rd_idx = 3'd0;
        fill_far();
        repeat (3) step();
        chk("rst_addr", 32'(oam_read_addr), 32'd0);
        chk("rst_cnt", 32'(sprite_count), 32'd0);
        chk("rst_ovf", 32'(sprite_overflow), 32'd0);
        chk("rst_done", 32'(eval_done), 32'd0);
        chk("rst_late", 32'(eval_late), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty_read", sec_rd_data, 32'hFFFF_FFFF);
`ifdef SPRITE_ZERO_FLAG_EN
        chk("rst_s0", 32'(sprite0_in_line), 32'd0);
`endif
        reset_n = 1'b1;
        repeat (2) step();

        // Single hit: entry 5 at Y=10 on line 12.
        fill_far();
        oam[5] = {8'd10, 24'($urandom)};
        begin_line(8'd12, 1'b0, "single_start");
        model(12, NENT);
        expect_done("single");
        step();
        chk("single_done_pulse", 32'(eval_done), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        step();
        begin_line(8'd200, 1'b0, "single_swap");
        chk("single_cnt_is_1", 32'(sprite_count), 32'd1);
        sec_rd_idx = 3'd0;
        #1;
        chk("single_slot0_entry5", sec_rd_data, oam[5]);
        sec_rd_idx = 3'd1;
        #1;
        chk("single_slot1_empty", sec_rd_data, 32'hFFFF_FFFF);
        model(200, NENT);
        expect_done("single_next");

        // Overflow: ten sprites on line 104, scan stops early.
        fill_far();
        for (int e = 0; e < 10; e++) oam[e] = {8'd100, 24'($urandom)};
        begin_line(8'd104, 1'b0, "ovf_start");
        model(104, NENT);
        expect_done("ovf");
        step();
        begin_line(8'd0, 1'b0, "ovf_swap");
        chk("ovf_cnt_is_8", 32'(sprite_count), 32'd8);
        chk("ovf_flag_set", 32'(sprite_overflow), 32'd1);
        model(0, NENT);
        expect_done("ovf_next");

        // Height edges for Y=100 and no-wrap for Y=250.
        fill_far();
        oam[33] = {8'd100, 24'($urandom)};
        begin_line(8'd100, 1'b0, "edge_l100_start");
        model(100, NENT);
        expect_done("edge_l100");
        begin_line(8'd107, 1'b0, "edge_l107_start");
        chk("edge_y100_l100_cnt", 32'(sprite_count), 32'd1);
        model(107, NENT);
        expect_done("edge_l107");
        begin_line(8'd108, 1'b0, "edge_l108_start");
        chk("edge_y100_l107_cnt", 32'(sprite_count), 32'd1);
        model(108, NENT);
        expect_done("edge_l108");
        oam[33] = {8'd250, 24'($urandom)};
        begin_line(8'd3, 1'b0, "edge_l3_start");
        chk("edge_y100_l108_cnt", 32'(sprite_count), 32'd0);
        model(3, NENT);
        expect_done("edge_l3");

        // Late line_start at T+30: only entries 0..27 were evaluated.
        fill_rand(50, 5);
        begin_line(8'd50, 1'b0, "late_a");
        chk("edge_y250_l3_cnt", 32'(sprite_count), 32'd0);
        model(50, 28);
        repeat (29) step();
        begin_line(8'd51, 1'b1, "late_b");
        model(51, NENT);
        expect_done("late_rescan");
        step();

        // Random lines; iteration 3 is followed by a line_start in the DONE cycle.
        for (int it = 0; it < 6; it++) begin
            ln = int'($urandom_range(0, 230));
            fill_rand(ln, int'($urandom_range(2, 12)));
            begin_line(8'(ln), 1'b0, $sformatf("rnd%0d", it));
            model(ln, NENT);
            expect_done($sformatf("rnd%0d", it));
            if (it != 3) repeat ($urandom_range(1, 4)) step();
        end

        // Reset at T+20 of a scan.
        begin_line(8'd0, 1'b0, "rnd_final");
        repeat (19) step();
        reset_n = 1'b0;
        step();
        chk("midrst_addr", 32'(oam_read_addr), 32'd0);
        chk("midrst_cnt", 32'(sprite_count), 32'd0);
        chk("midrst_ovf", 32'(sprite_overflow), 32'd0);
        chk("midrst_done", 32'(eval_done), 32'd0);
        chk("midrst_late", 32'(eval_late), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        sec_rd_idx = 3'd0;
        #1;
        chk("midrst_empty_read", sec_rd_data, 32'hFFFF_FFFF);
`ifdef SPRITE_ZERO_FLAG_EN
        chk("midrst_s0", 32'(sprite0_in_line), 32'd0);
`endif
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            step();
            if (busy === 1'b1 || eval_done === 1'b1) seen = 1'b1;
        end
        chk("midrst_stays_idle", 32'(seen), 32'd0);
        chk("midrst_cnt_after", 32'(sprite_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
